// File: rtl/burst_ram_sim_pkg.sv
// burst_ram_sim shared types and default parameters.
// Controller states and default sizing constants.
package burst_ram_sim_pkg;

  localparam int DEF_DATA_BITWIDTH            = 64;
  localparam int DEF_DEPTH_BITWIDTH           = 4;
  localparam int DEF_BURST_COUNT              = 4;
  localparam int DEF_CYCLES_BEFORE_INITIATED  = 10;
  localparam int DEF_CYCLES_BEFORE_DATA_VALID = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ
  } state_e;

endpackage

// File: rtl/burst_ram_sim_if.sv
// burst_ram_sim host-side bundle (command, write and read beats).
// Optional protocol_err is present with BURST_RAM_SIM_PROTOCOL_ERR_EN.
interface burst_ram_sim_if #(
  parameter int DW = 64,
  parameter int AW = 4
) ();

  logic            cmd;
  logic            cmd_en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] data_mask;
  logic [DW-1:0]   rd_data;
  logic            rd_data_valid;
  logic            busy;
  logic            init_calib;
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
  logic            protocol_err;
`endif

  modport master (
    output cmd,
    output cmd_en,
    output addr,
    output wr_data,
    output data_mask,
    input  rd_data,
    input  rd_data_valid,
    input  busy,
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
    input  protocol_err,
`endif
    input  init_calib
  );

  modport slave (
    input  cmd,
    input  cmd_en,
    input  addr,
    input  wr_data,
    input  data_mask,
    output rd_data,
    output rd_data_valid,
    output busy,
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
    output protocol_err,
`endif
    output init_calib
  );

endinterface

// File: rtl/burst_ram_sim_mem.sv
// burst_ram_sim beat array: one byte-masked write port, one async read.
// Contents are deliberately not reset so data survives rst_n.
module burst_ram_sim_mem #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wmask,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];

  // Byte-granular write; a set mask bit keeps the old byte.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && !wmask[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_ram_sim.sv
// burst_ram_sim: behavioural burst RAM with init delay and read latency.
// Define BURST_RAM_SIM_PROTOCOL_ERR_EN to add the sticky protocol_err output.
module burst_ram_sim
  import burst_ram_sim_pkg::*;
#(
  parameter int DATA_BITWIDTH            = DEF_DATA_BITWIDTH,
  parameter int DEPTH_BITWIDTH           = DEF_DEPTH_BITWIDTH,
  parameter int BURST_COUNT              = DEF_BURST_COUNT,
  parameter int CYCLES_BEFORE_INITIATED  = DEF_CYCLES_BEFORE_INITIATED,
  parameter int CYCLES_BEFORE_DATA_VALID = DEF_CYCLES_BEFORE_DATA_VALID
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd,
  input  logic                       cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]  addr,
  input  logic [DATA_BITWIDTH-1:0]   wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] data_mask,
  output logic [DATA_BITWIDTH-1:0]   rd_data,
  output logic                       rd_data_valid,
  output logic                       busy,
  output logic                       init_calib
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
  ,
  output logic                       protocol_err
`endif
);

  localparam int DW = DATA_BITWIDTH;
  localparam int AW = DEPTH_BITWIDTH;
  localparam int BW = $clog2(BURST_COUNT + 1);

  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_COUNT - 1);
  localparam logic [BW-1:0] BEAT_END  = BW'(BURST_COUNT);
  localparam logic [31:0]   INIT_LAST = 32'(CYCLES_BEFORE_INITIATED - 1);
  localparam logic [31:0]   WAIT_LAST = 32'(CYCLES_BEFORE_DATA_VALID - 1);
  localparam logic          MULTI     = (BURST_COUNT > 1);

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [AW-1:0]   base_q, base_d;
  logic            busy_q, busy_d;
  logic            init_q, init_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic            vld_q, vld_d;

  logic            accept;
  logic [AW-1:0]   beat_addr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_rdata;

  // Commands are only taken in IDLE (ready and not bursting).
  assign accept    = cmd_en && (state_q == ST_IDLE);
  assign beat_addr = base_q + AW'(beat_q);

  burst_ram_sim_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .wmask (data_mask),
    .raddr (beat_addr),
    .rdata (mem_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          if (!cmd)       state_d = ST_READ_WAIT;
          else if (MULTI) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (beat_q == BEAT_LAST) state_d = ST_IDLE;
      end
      ST_READ_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_READ;
      end
      ST_READ: begin
        if (beat_q == BEAT_END) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Counters, beat sequencing, memory strobes and registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    busy_d    = busy_q;
    init_d    = init_q;
    rd_d      = rd_q;
    vld_d     = vld_q;
    mem_we    = 1'b0;
    mem_waddr = beat_addr;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d  = '0;
          init_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          base_d = addr;
          cnt_d  = '0;
          if (cmd) begin
            // Beat 0 lands on the command edge itself.
            mem_we    = 1'b1;
            mem_waddr = addr;
            beat_d    = BEAT_ONE;
            busy_d    = MULTI;
          end else begin
            beat_d = '0;
            busy_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          busy_d = 1'b0;
        end else begin
          beat_d = beat_q + BEAT_ONE;
        end
      end
      ST_READ_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rd_d   = mem_rdata;
          vld_d  = 1'b1;
          beat_d = BEAT_ONE;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_READ: begin
        if (beat_q == BEAT_END) begin
          vld_d  = 1'b0;
          busy_d = 1'b0;
          beat_d = '0;
        end else begin
          rd_d   = mem_rdata;
          beat_d = beat_q + BEAT_ONE;
        end
      end
      default: begin
        cnt_d  = '0;
        beat_d = '0;
      end
    endcase
  end

  assign rd_data       = rd_q;
  assign rd_data_valid = vld_q;
  assign busy          = busy_q;
  assign init_calib    = init_q;

`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
  logic perr_q, perr_d;

  // Sticky flag for any strobe that arrives while not ready.
  always_comb begin
    perr_d = perr_q | (cmd_en & ~accept);
  end

  // Cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign protocol_err = perr_q;
`endif

endmodule

// File: tb/tb_burst_ram_sim.sv
// tb_burst_ram_sim: scoreboard bench for burst_ram_sim.
// Read beats are predicted from a byte-masked model and popped on rd_data_valid.
module tb_burst_ram_sim;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int BC = 4;
  localparam int CI = 10;
  localparam int CD = 6;

  typedef logic [DW-1:0] beats_t [BC];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  burst_ram_sim_if #(.DW(DW), .AW(AW)) bus ();

  burst_ram_sim #(
    .DATA_BITWIDTH            (DW),
    .DEPTH_BITWIDTH           (AW),
    .BURST_COUNT              (BC),
    .CYCLES_BEFORE_INITIATED  (CI),
    .CYCLES_BEFORE_DATA_VALID (CD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (bus.cmd),
    .cmd_en        (bus.cmd_en),
    .addr          (bus.addr),
    .wr_data       (bus.wr_data),
    .data_mask     (bus.data_mask),
    .rd_data       (bus.rd_data),
    .rd_data_valid (bus.rd_data_valid),
    .busy          (bus.busy),
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
    .protocol_err  (bus.protocol_err),
`endif
    .init_calib    (bus.init_calib)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Beats are popped when the DUT presents them.
  always @(negedge clk) begin
    if (rst_n && bus.rd_data_valid) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 64'(bus.rd_data_valid), 64'd0);
      end else begin
        chk("rd_beat", bus.rd_data, sb.pop_front());
      end
    end
  end

  task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [7:0] m);
    for (int b = 0; b < DW / 8; b++) begin
      if (!m[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 64 && !(bus.init_calib && !bus.busy); i++) tick();
    if (!(bus.init_calib && !bus.busy)) begin
      chk("ready_timeout", 64'(bus.init_calib & ~bus.busy), 64'd1);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_init"}, 64'(bus.init_calib), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_vld"}, 64'(bus.rd_data_valid), 64'd0);
    chk({tag, "_rd"}, bus.rd_data, 64'd0);
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
    chk({tag, "_perr"}, 64'(bus.protocol_err), 64'd0);
`endif
  endtask

  // Release reset and time init_calib; optionally poke cmd_en at edge 5.
  task automatic init_seq(input bit poke);
    rst_n = 1'b1;
    for (int k = 1; k <= CI; k++) begin
      tick();
      if (poke && k == 4) begin
        bus.cmd = 1'b1;
        bus.cmd_en = 1'b1;
        bus.addr = 4'd8;
        bus.wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.data_mask = 8'h00;
      end
      if (poke && k == 5) begin
        bus.cmd_en = 1'b0;
        chk("init_ign_busy", 64'(bus.busy), 64'd0);
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
        chk("init_ign_perr", 64'(bus.protocol_err), 64'd1);
`endif
      end
      if (k == CI - 1) chk("init_early", 64'(bus.init_calib), 64'd0);
      if (k == CI) chk("init_rise", 64'(bus.init_calib), 64'd1);
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input beats_t d,
                             input logic [7:0] m, input int abort_at);
    bit aborted = 1'b0;
    wait_ready();
    bus.cmd = 1'b1;
    bus.cmd_en = 1'b1;
    bus.addr = a;
    bus.wr_data = d[0];
    bus.data_mask = m;
    for (int i = 0; i < BC; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        aborted = 1'b1;
        break;
      end
      model_wr(a + AW'(i), d[i], m);
      tick();
      bus.cmd_en = 1'b0;
      if (i == 0) chk("wr_busy", 64'(bus.busy), 64'd1);
      if (i < BC - 1) bus.wr_data = d[i+1];
    end
    if (!aborted) chk("wr_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input bit inject);
    wait_ready();
    for (int i = 0; i < BC; i++) sb.push_back(model[a + AW'(i)]);
    bus.cmd = 1'b0;
    bus.cmd_en = 1'b1;
    bus.addr = a;
    tick();
    bus.cmd_en = 1'b0;
    chk("rd_busy", 64'(bus.busy), 64'd1);
    for (int k = 1; k <= CD + BC; k++) begin
      tick();
      if (k == CD - 1) chk("rd_vld_early", 64'(bus.rd_data_valid), 64'd0);
      if (k == CD) chk("rd_vld_first", 64'(bus.rd_data_valid), 64'd1);
      if (inject && k == CD + 1) begin
        bus.cmd = 1'b1;
        bus.cmd_en = 1'b1;
        bus.addr = a;
        bus.wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.data_mask = 8'h00;
      end
      if (inject && k == CD + 2) begin
        bus.cmd_en = 1'b0;
`ifdef BURST_RAM_SIM_PROTOCOL_ERR_EN
        chk("rd_ign_perr", 64'(bus.protocol_err), 64'd1);
`endif
      end
      if (k == CD + BC - 1) chk("rd_busy_last", 64'(bus.busy), 64'd1);
      if (k == CD + BC) begin
        chk("rd_busy_end", 64'(bus.busy), 64'd0);
        chk("rd_vld_end", 64'(bus.rd_data_valid), 64'd0);
        chk("rd_hold", bus.rd_data, model[a + AW'(BC - 1)]);
      end
    end
  endtask

  initial begin
    beats_t d;
    bus.cmd = 1'b0;
    bus.cmd_en = 1'b0;
    bus.addr = '0;
    bus.wr_data = '0;
    bus.data_mask = '0;

    tick(2);
    chk_reset_outs("rst");
    init_seq(1'b1);

    for (int i = 0; i < BC; i++) d[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    write_burst(4'd2, d, 8'h00, -1);
    read_burst(4'd2, 1'b0);

    for (int i = 0; i < BC; i++) d[i] = 64'hA5A5_0000_0000_0000 + 64'(i + 1);
    write_burst(4'd14, d, 8'h00, -1);
    read_burst(4'd0, 1'b0);

    for (int i = 0; i < BC; i++) d[i] = '1;
    write_burst(4'd8, d, 8'h00, -1);
    for (int i = 0; i < BC; i++) d[i] = '0;
    write_burst(4'd8, d, 8'h0F, -1);
    read_burst(4'd8, 1'b1);
    read_burst(4'd8, 1'b0);

    for (int i = 0; i < BC; i++) d[i] = 64'hC0C0_C0C0_C0C0_C0C0 + 64'(i);
    write_burst(4'd2, d, 8'h00, 2);
    tick(2);
    init_seq(1'b0);
    read_burst(4'd2, 1'b0);

    tick(2);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
